// File: rtl/cache_tag_pkg.sv
// Shared definitions for the direct-mapped cache tag controller.
//
// Contents:
//   DEF_AWIDTH / DEF_DWIDTH : default index width and tag RAM word width
//   state_t                 : controller state encoding
//   valid_pos()             : bit position of the valid flag in a tag word
package cache_tag_pkg;

    localparam int DEF_AWIDTH = 3;
    localparam int DEF_DWIDTH = 7;

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_CMP    = 3'd2,
        ST_REFILL = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    // The valid flag is the MSB of a tag word; the tag occupies the rest.
    function automatic int valid_pos(input int dwidth);
        return dwidth - 1;
    endfunction

endpackage

// File: rtl/cache_tag_match.sv
// Combinational valid + tag comparator for one way.
//
// Ports:
//   entry  in  DWIDTH    stored tag word {valid, tag}
//   tag    in  DWIDTH-1  request tag
//   hit    out 1         entry is valid and its tag equals the request tag
module cache_tag_match
    import cache_tag_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic [DWIDTH-1:0] entry,
    input  logic [DWIDTH-2:0] tag,
    output logic              hit
);

    always_comb begin
        hit = entry[valid_pos(DWIDTH)] && (entry[DWIDTH-2:0] == tag);
    end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag controller. Drives an external synchronous-read
// tag RAM, answers lookups with hit/miss, runs a refill handshake on a miss
// and writes the new tag back. Invalidates every entry after reset or when
// flush is requested.
//
// Ports:
//   clock, reset               sole clock; synchronous active-high reset
//   req_valid/req_ready/req_addr  lookup request, req_addr = {tag, index}
//   resp_valid/resp_hit/resp_index one-cycle registered response
//   refill_req/refill_addr/refill_ack miss refill handshake
//   flush                      invalidate-all request (honoured in IDLE)
//   busy                       controller not in IDLE
//   tag_addr/tag_we/tag_din    to tag RAM
//   tag_dout                   from tag RAM, for the previous cycle's address
module cache_tag_ctrl
    import cache_tag_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH,
    localparam int TWIDTH = DWIDTH - 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AWIDTH+TWIDTH-1:0] req_addr,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [AWIDTH-1:0]        resp_index,
    output logic                     refill_req,
    output logic [AWIDTH+TWIDTH-1:0] refill_addr,
    input  logic                     refill_ack,
    input  logic                     flush,
    output logic                     busy,
    output logic [AWIDTH-1:0]        tag_addr,
    output logic                     tag_we,
    output logic [DWIDTH-1:0]        tag_din,
    input  logic [DWIDTH-1:0]        tag_dout
);

    state_t                     state_q, state_d;
    logic [AWIDTH-1:0]          cnt_q, cnt_d;
    logic [AWIDTH+TWIDTH-1:0]   req_q, req_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_hit_q, resp_hit_d;
    logic [AWIDTH-1:0]          resp_index_q, resp_index_d;

    logic [AWIDTH-1:0]          req_index;
    logic [TWIDTH-1:0]          req_tag;
    logic                       hit;

    assign req_index = req_q[AWIDTH-1:0];
    assign req_tag   = req_q[AWIDTH+TWIDTH-1:AWIDTH];

    cache_tag_match #(
        .DWIDTH (DWIDTH)
    ) u_match (
        .entry (tag_dout),
        .tag   (req_tag),
        .hit   (hit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        req_ready    = 1'b0;
        refill_req   = 1'b0;
        tag_we       = 1'b0;
        tag_addr     = req_index;
        tag_din      = '0;

        case (state_q)
            ST_FLUSH: begin
                tag_we   = 1'b1;
                tag_addr = cnt_q;
                cnt_d    = cnt_q + AWIDTH'(1);
                if (cnt_q == {AWIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = !flush;
                // Present the incoming index now so the RAM latches it at
                // the accept edge and the data is ready during CMP.
                tag_addr  = req_addr[AWIDTH-1:0];
                if (flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    req_d   = req_addr;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_index_d = req_index;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                refill_req = 1'b1;
                if (refill_ack) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                tag_we       = 1'b1;
                tag_din      = {1'b1, req_tag};
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b0;
                resp_index_d = req_index;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_hit    = resp_hit_q;
    assign resp_index  = resp_index_q;
    assign refill_addr = req_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
